mem_ctrl: RTL and testbench
===========================

MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, address width for pc/mar/req_addr.
REQ-002 SHALL have parameter TIMEOUT, default 255, maximum cycles waiting for rsp_valid before abort.
REQ-003 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port romo, input, 1: CPU ROM fetch request (level).
REQ-006 SHALL have port ramo, input, 1: CPU RAM read request (level).
REQ-007 SHALL have port rami, input, 1: CPU RAM write request (level).
REQ-008 SHALL have port pc, input, ADDR_W: ROM fetch address.
REQ-009 SHALL have port mar, input, ADDR_W: RAM address.
REQ-010 SHALL have port wdata, input, 8: RAM write data.
REQ-011 SHALL have port rdata, output, 8: last read byte, held until the next read completes.
REQ-012 SHALL have port executing, output, 1: high = CPU may advance; low = stall.
REQ-013 SHALL have port err, output, 1: sticky timeout flag.
REQ-014 SHALL have port req_valid, output, 1: transaction request to SPI engine.
REQ-015 SHALL have port req_ready, input, 1: SPI engine accepts request.
REQ-016 SHALL have port req_write, output, 1: 1 = write (command 0x02), 0 = read (0x03).
REQ-017 SHALL have port req_target, output, 1: 0 = ROM chip select, 1 = RAM chip select.
REQ-018 SHALL have ports req_addr (output, ADDR_W) and req_wdata (output, 8): request payload.
REQ-019 SHALL have ports rsp_valid (input, 1: one-cycle completion pulse) and rsp_data (input, 8: read byte).

Function
REQ-020 SHALL detect rising edges of romo, ramo, rami and set per-source pending bits; levels held high SHALL NOT re-trigger.
REQ-021 SHALL serve pending bits in priority romo > ramo > rami; edges arriving together SHALL be served back-to-back, one transaction each.
REQ-022 SHALL implement states IDLE, ISSUE, WAIT, DONE: IDLE->ISSUE when any pending bit set; ISSUE->WAIT on req_valid&&req_ready; WAIT->DONE on rsp_valid or timeout; DONE->IDLE after one cycle, or DONE->ISSUE if another bit pending.
REQ-023 SHALL latch address (pc for ROM, mar for RAM), req_write, req_target and wdata on entering ISSUE; payload SHALL stay stable while req_valid high.
REQ-024 SHALL hold req_valid high in ISSUE until accepted; SHALL NOT drop it before req_ready.
REQ-025 SHALL load rdata from rsp_data on rsp_valid in WAIT for reads only; writes leave rdata unchanged.
REQ-026 SHALL drive executing low from the cycle after a request edge until the DONE cycle of the last pending transaction; executing high in IDLE with nothing pending.
REQ-027 SHALL ignore rsp_valid outside WAIT.
REQ-028 SHALL count WAIT cycles; on reaching TIMEOUT without rsp_valid, SHALL set rdata=8'hFF for reads, set err, and go to DONE.
REQ-029 SHALL complete an in-flight transaction even if its request level falls; result is still written to rdata.
REQ-030 SHALL give minimum latency of 3 cycles from request edge to executing high with zero-wait engine (ISSUE, WAIT, DONE).

Reset
REQ-031 SHALL on rst: state IDLE, pending bits 0, edge history 0, rdata 0, err 0, req_valid 0, req_write 0, req_target 0, req_addr 0, req_wdata 0, executing 1, timeout counter 0.
REQ-032 SHALL abort any transaction when rst asserts mid-operation; req_valid low the following cycle.

Configuration
REQ-033 SHALL support macro MEM_CTRL_WRITE_EN: defined -> rami edges issue write transactions per REQ-021..025.
REQ-034 SHALL, without MEM_CTRL_WRITE_EN, never assert req_write; rami edges SHALL be dropped with no stall, no bus activity.

Structure
REQ-035 SHALL place state encoding, READ_CMD=0x03, WRITE_CMD=0x02 and TARGET_ROM/TARGET_RAM constants in shared package mem_pkg.
REQ-036 SHALL be a single module; the edge-detect/pending-priority logic may be sub-module mem_req_pick.

Verification
REQ-037 SHALL test romo edge, pc=0x1234, engine returns 0xA5 after 10 cycles -> req_addr=0x1234, req_target=0, rdata=0xA5, executing high in DONE.
REQ-038 SHALL test romo and ramo rising same cycle, mar=0x0040 -> ROM transaction first, then RAM transaction at 0x0040, executing low throughout both.
REQ-039 SHALL test rami edge, mar=0x00FF, wdata=0x3C with MEM_CTRL_WRITE_EN -> req_write=1, req_wdata=0x3C, rdata unchanged; without macro -> no req_valid.
REQ-040 SHALL test no rsp_valid with TIMEOUT=8 -> rdata=0xFF, err=1 after 8 WAIT cycles, executing returns high.
REQ-041 SHALL test rst asserted in WAIT -> all outputs at reset values next cycle, later rsp_valid ignored.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the memory controller: FSM state encoding,
// SPI command bytes, chip-select targets and the request priority picker.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [7:0] READ_CMD   = 8'h03;
  localparam logic [7:0] WRITE_CMD  = 8'h02;
  localparam logic       TARGET_ROM = 1'b0;
  localparam logic       TARGET_RAM = 1'b1;

  // Bit positions of the request sources; lower index wins.
  // bit 0 = ROM fetch (romo), bit 1 = RAM read (ramo), bit 2 = RAM write (rami)
  function automatic logic [2:0] pick_first(input logic [2:0] req);
    logic [2:0] grant;
    grant = 3'b000;
    if (req[0]) begin
      grant = 3'b001;
    end else if (req[1]) begin
      grant = 3'b010;
    end else if (req[2]) begin
      grant = 3'b100;
    end else begin
      grant = 3'b000;
    end
    return grant;
  endfunction

endpackage

// File: rtl/mem_req_pick.sv
// Rising-edge detection of the CPU request levels, per-source pending bits
// and fixed-priority selection (ROM > RAM read > RAM write).
// Macro MEM_CTRL_WRITE_EN: when undefined, RAM write edges are discarded.
module mem_req_pick
  import mem_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [2:0] src_i,
  input  logic       take_i,
  output logic [2:0] grant_o,
  output logic       any_o,
  output logic       pend_next_o
);

`ifdef MEM_CTRL_WRITE_EN
  localparam logic [2:0] SRC_MASK = 3'b111;
`else
  localparam logic [2:0] SRC_MASK = 3'b011;
`endif

  logic [2:0] hist_q;
  logic [2:0] pend_q;
  logic [2:0] pend_d;
  logic [2:0] rise_s;
  logic [2:0] avail_s;

  // New edges join the pending set immediately so IDLE can issue in the same cycle.
  always_comb begin
    rise_s      = src_i & ~hist_q & SRC_MASK;
    avail_s     = pend_q | rise_s;
    grant_o     = pick_first(avail_s);
    any_o       = |avail_s;
    if (take_i) begin
      pend_d = avail_s & ~grant_o;
    end else begin
      pend_d = avail_s;
    end
    pend_next_o = |pend_d;
  end

  // Edge history and pending bits.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hist_q <= 3'b000;
      pend_q <= 3'b000;
    end else begin
      hist_q <= src_i;
      pend_q <= pend_d;
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// Memory controller: turns CPU ROM/RAM request edges into single-byte
// transactions for an SPI engine, stalling the CPU while work is outstanding.
// Macro MEM_CTRL_WRITE_EN enables RAM write transactions (default: disabled).
module mem_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              romo,
  input  logic              ramo,
  input  logic              rami,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] mar,
  input  logic [7:0]        wdata,
  output logic [7:0]        rdata,
  output logic              executing,
  output logic              err,
  output logic              req_valid,
  input  logic              req_ready,
  output logic              req_write,
  output logic              req_target,
  output logic [ADDR_W-1:0] req_addr,
  output logic [7:0]        req_wdata,
  input  logic              rsp_valid,
  input  logic [7:0]        rsp_data
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              req_valid_q, req_valid_d;
  logic              req_write_q, req_write_d;
  logic              req_target_q, req_target_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [7:0]        req_wdata_q, req_wdata_d;
  logic              executing_q, executing_d;

  logic [2:0]        grant_s;
  logic              any_s;
  logic              take_s;
  logic              pend_next_s;
  logic [7:0]        cmd_s;

  assign take_s = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && any_s;

  mem_req_pick u_pick (
    .clk_i       (clk),
    .rst_i       (rst),
    .src_i       ({rami, ramo, romo}),
    .take_i      (take_s),
    .grant_o     (grant_s),
    .any_o       (any_s),
    .pend_next_o (pend_next_s)
  );

  // Next-state, payload capture, completion and timeout handling.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    req_valid_d  = req_valid_q;
    req_write_d  = req_write_q;
    req_target_d = req_target_q;
    req_addr_d   = req_addr_q;
    req_wdata_d  = req_wdata_q;
    // Command byte the engine will emit; the write flag is derived from it.
    cmd_s        = grant_s[2] ? WRITE_CMD : READ_CMD;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (take_s) begin
          state_d      = ST_ISSUE;
          req_valid_d  = 1'b1;
          req_addr_d   = grant_s[0] ? pc : mar;
          req_target_d = grant_s[0] ? TARGET_ROM : TARGET_RAM;
          req_write_d  = (cmd_s == WRITE_CMD);
          req_wdata_d  = wdata;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (req_valid_q && req_ready) begin
          state_d     = ST_WAIT;
          req_valid_d = 1'b0;
          cnt_d       = {CNT_W{1'b0}};
        end else begin
          req_valid_d = 1'b1;
        end
      end
      ST_WAIT: begin
        if (rsp_valid) begin
          if (!req_write_q) begin
            rdata_d = rsp_data;
          end else begin
            rdata_d = rdata_q;
          end
          state_d = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          if (!req_write_q) begin
            rdata_d = 8'hFF;
          end else begin
            rdata_d = rdata_q;
          end
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d     = ST_IDLE;
        req_valid_d = 1'b0;
      end
    endcase

    // CPU may run only when nothing is in flight and nothing is queued.
    executing_d = !((state_d == ST_ISSUE) || (state_d == ST_WAIT) || pend_next_s);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= {CNT_W{1'b0}};
      rdata_q      <= 8'h00;
      err_q        <= 1'b0;
      req_valid_q  <= 1'b0;
      req_write_q  <= 1'b0;
      req_target_q <= 1'b0;
      req_addr_q   <= {ADDR_W{1'b0}};
      req_wdata_q  <= 8'h00;
      executing_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      req_valid_q  <= req_valid_d;
      req_write_q  <= req_write_d;
      req_target_q <= req_target_d;
      req_addr_q   <= req_addr_d;
      req_wdata_q  <= req_wdata_d;
      executing_q  <= executing_d;
    end
  end

  assign rdata      = rdata_q;
  assign err        = err_q;
  assign req_valid  = req_valid_q;
  assign req_write  = req_write_q;
  assign req_target = req_target_q;
  assign req_addr   = req_addr_q;
  assign req_wdata  = req_wdata_q;
  assign executing  = executing_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: one instance with default TIMEOUT, one with
// TIMEOUT=8 for the abort path. Honours MEM_CTRL_WRITE_EN for the write test.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  // instance A (default TIMEOUT)
  logic        romo, ramo, rami, req_ready, rsp_valid;
  logic [15:0] pc, mar;
  logic [7:0]  wdata, rsp_data;
  logic [7:0]  rdata, req_wdata;
  logic        executing, err, req_valid, req_write, req_target;
  logic [15:0] req_addr;
  // instance B (TIMEOUT = 8)
  logic        b_romo, b_ramo, b_rami, b_req_ready, b_rsp_valid;
  logic [15:0] b_pc, b_mar;
  logic [7:0]  b_wdata, b_rsp_data;
  logic [7:0]  b_rdata, b_req_wdata;
  logic        b_executing, b_err, b_req_valid, b_req_write, b_req_target;
  logic [15:0] b_req_addr;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_ctrl #(.ADDR_W(16)) u_dut (
    .clk(clk), .rst(rst), .romo(romo), .ramo(ramo), .rami(rami),
    .pc(pc), .mar(mar), .wdata(wdata), .rdata(rdata),
    .executing(executing), .err(err), .req_valid(req_valid),
    .req_ready(req_ready), .req_write(req_write), .req_target(req_target),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data)
  );

  mem_ctrl #(.ADDR_W(16), .TIMEOUT(8)) u_dut_to (
    .clk(clk), .rst(rst), .romo(b_romo), .ramo(b_ramo), .rami(b_rami),
    .pc(b_pc), .mar(b_mar), .wdata(b_wdata), .rdata(b_rdata),
    .executing(b_executing), .err(b_err), .req_valid(b_req_valid),
    .req_ready(b_req_ready), .req_write(b_req_write), .req_target(b_req_target),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_data(b_rsp_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    romo = 1'b0; ramo = 1'b0; rami = 1'b0; req_ready = 1'b0; rsp_valid = 1'b0;
    pc = 16'h0000; mar = 16'h0000; wdata = 8'h00; rsp_data = 8'h00;
    b_romo = 1'b0; b_ramo = 1'b0; b_rami = 1'b0; b_req_ready = 1'b0; b_rsp_valid = 1'b0;
    b_pc = 16'h0ABC; b_mar = 16'h0000; b_wdata = 8'h00; b_rsp_data = 8'h00;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Reset values
    chk("rst_rdata", {24'd0, rdata}, 32'h00);
    chk("rst_err", {31'd0, err}, 32'h0);
    chk("rst_req_valid", {31'd0, req_valid}, 32'h0);
    chk("rst_executing", {31'd0, executing}, 32'h1);
    chk("rst_req_addr", {16'd0, req_addr}, 32'h0);
    chk("rst_req_target", {31'd0, req_target}, 32'h0);

    // ROM fetch at 0x1234, engine answers 0xA5 after 10 cycles
    pc = 16'h1234; romo = 1'b1;
    tick();
    chk("rom_req_valid", {31'd0, req_valid}, 32'h1);
    chk("rom_req_addr", {16'd0, req_addr}, 32'h1234);
    chk("rom_req_target", {31'd0, req_target}, 32'h0);
    chk("rom_req_write", {31'd0, req_write}, 32'h0);
    chk("rom_stall", {31'd0, executing}, 32'h0);
    tick();
    chk("rom_valid_held", {31'd0, req_valid}, 32'h1);
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    chk("rom_valid_drop", {31'd0, req_valid}, 32'h0);
    for (int i = 0; i < 9; i++) tick();
    chk("rom_stall_wait", {31'd0, executing}, 32'h0);
    rsp_valid = 1'b1; rsp_data = 8'hA5;
    tick();
    rsp_valid = 1'b0;
    chk("rom_rdata", {24'd0, rdata}, 32'hA5);
    chk("rom_exec_done", {31'd0, executing}, 32'h1);
    tick(); tick();
    chk("rom_no_retrigger", {31'd0, req_valid}, 32'h0);
    chk("rom_exec_idle", {31'd0, executing}, 32'h1);
    romo = 1'b0;
    tick();

    // rsp_valid outside WAIT is ignored
    rsp_valid = 1'b1; rsp_data = 8'h77;
    tick();
    rsp_valid = 1'b0;
    chk("idle_rsp_ignored", {24'd0, rdata}, 32'hA5);

    // Simultaneous ROM + RAM read edges, zero-wait engine
    pc = 16'h2000; mar = 16'h0040; romo = 1'b1; ramo = 1'b1; req_ready = 1'b1;
    tick();
    chk("dual_first_target", {31'd0, req_target}, 32'h0);
    chk("dual_first_addr", {16'd0, req_addr}, 32'h2000);
    chk("dual_stall1", {31'd0, executing}, 32'h0);
    tick();
    rsp_valid = 1'b1; rsp_data = 8'h11;
    tick();
    rsp_valid = 1'b0;
    chk("dual_first_rdata", {24'd0, rdata}, 32'h11);
    chk("dual_stall_done1", {31'd0, executing}, 32'h0);
    tick();
    chk("dual_second_valid", {31'd0, req_valid}, 32'h1);
    chk("dual_second_target", {31'd0, req_target}, 32'h1);
    chk("dual_second_addr", {16'd0, req_addr}, 32'h0040);
    chk("dual_stall2", {31'd0, executing}, 32'h0);
    tick();
    rsp_valid = 1'b1; rsp_data = 8'h22;
    tick();
    rsp_valid = 1'b0; req_ready = 1'b0;
    chk("dual_second_rdata", {24'd0, rdata}, 32'h22);
    chk("dual_exec_done", {31'd0, executing}, 32'h1);
    romo = 1'b0; ramo = 1'b0;
    tick(); tick();

    // Minimum latency: three cycles from edge to executing high
    romo = 1'b1; req_ready = 1'b1;
    tick();
    chk("lat_c1", {31'd0, executing}, 32'h0);
    tick();
    chk("lat_c2", {31'd0, executing}, 32'h0);
    rsp_valid = 1'b1; rsp_data = 8'h5A;
    tick();
    rsp_valid = 1'b0; req_ready = 1'b0; romo = 1'b0;
    chk("lat_c3", {31'd0, executing}, 32'h1);
    chk("lat_rdata", {24'd0, rdata}, 32'h5A);
    tick();

    // RAM write edge
    mar = 16'h00FF; wdata = 8'h3C; rami = 1'b1;
    tick();
`ifdef MEM_CTRL_WRITE_EN
    chk("wr_valid", {31'd0, req_valid}, 32'h1);
    chk("wr_write", {31'd0, req_write}, 32'h1);
    chk("wr_wdata", {24'd0, req_wdata}, 32'h3C);
    chk("wr_addr", {16'd0, req_addr}, 32'h00FF);
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    rsp_valid = 1'b1; rsp_data = 8'h99;
    tick();
    rsp_valid = 1'b0;
    chk("wr_rdata_kept", {24'd0, rdata}, 32'h5A);
    chk("wr_exec_done", {31'd0, executing}, 32'h1);
`else
    chk("wr_dropped_valid", {31'd0, req_valid}, 32'h0);
    chk("wr_dropped_exec", {31'd0, executing}, 32'h1);
    tick();
    chk("wr_dropped_valid2", {31'd0, req_valid}, 32'h0);
    chk("wr_never_write", {31'd0, req_write}, 32'h0);
`endif
    rami = 1'b0;
    tick();

    // Timeout on instance B (TIMEOUT = 8)
    b_romo = 1'b1; b_req_ready = 1'b1;
    tick();
    chk("to_issue", {31'd0, b_req_valid}, 32'h1);
    tick();
    b_req_ready = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("to_not_yet_err", {31'd0, b_err}, 32'h0);
    chk("to_not_yet_exec", {31'd0, b_executing}, 32'h0);
    tick();
    chk("to_err", {31'd0, b_err}, 32'h1);
    chk("to_rdata", {24'd0, b_rdata}, 32'hFF);
    chk("to_exec", {31'd0, b_executing}, 32'h1);
    tick();
    chk("to_err_sticky", {31'd0, b_err}, 32'h1);
    b_romo = 1'b0;

    // Reset while waiting for a response
    romo = 1'b1; pc = 16'h4321; req_ready = 1'b1;
    tick();
    tick();
    req_ready = 1'b0;
    chk("rstw_in_wait", {31'd0, executing}, 32'h0);
    rst = 1'b1; romo = 1'b0;
    tick();
    rst = 1'b0;
    chk("rstw_rdata", {24'd0, rdata}, 32'h00);
    chk("rstw_req_valid", {31'd0, req_valid}, 32'h0);
    chk("rstw_exec", {31'd0, executing}, 32'h1);
    chk("rstw_req_addr", {16'd0, req_addr}, 32'h0);
    chk("rstw_b_err", {31'd0, b_err}, 32'h0);
    rsp_valid = 1'b1; rsp_data = 8'h55;
    tick();
    rsp_valid = 1'b0;
    chk("rstw_rsp_ignored", {24'd0, rdata}, 32'h00);
    chk("rstw_exec_after", {31'd0, executing}, 32'h1);
    chk("rstw_valid_after", {31'd0, req_valid}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
